barrel_shift_16bit_left_pipe: RTL

BARREL_SHIFT_16BIT_LEFT_PIPE -- requirements
Module: barrel_shift_16bit_left_pipe

---
 rtl/barrel_shift_16bit_left_pipe_if.sv | 16 +
 rtl/barrel_shift_16bit_left_pipe.sv | 81 ++++++++
 2 files changed

// File: rtl/barrel_shift_16bit_left_pipe_if.sv
// barrel_shift_16bit_left_pipe_if: valid/ready bus for the pipelined 16-bit left barrel shifter
// in_valid/in_ready/in_data/in_ctrl/in_rot : upstream offer (operand, shift amount, rotate select)
// out_valid/out_ready/out_data             : downstream result
// master drives the offer and consumes results; slave is the shifter
interface barrel_shift_16bit_left_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_ctrl;
  logic        in_rot;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  modport master (output in_valid, in_data, in_ctrl, in_rot, out_ready, input in_ready, out_valid, out_data);
  modport slave (input in_valid, in_data, in_ctrl, in_rot, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/barrel_shift_16bit_left_pipe.sv
// barrel_shift_16bit_left_pipe: 4-stage pipelined 16-bit left shifter (8/4/2/1 per stage) with valid/ready flow control
// clk   : rising-edge clock
// rst_n : asynchronous active-low reset, empties the pipeline
// bus   : slave side of barrel_shift_16bit_left_pipe_if (input offer, output result)
// BARREL_SHIFT_ROTATE_EN : when defined, in_rot=1 selects rotate-left; otherwise in_rot is ignored
module barrel_shift_16bit_left_pipe (
  input logic clk,
  input logic rst_n,
  barrel_shift_16bit_left_pipe_if.slave bus
);
  logic        v1, v2, v3, v4;
  logic [15:0] d1, d2, d3, d4;
  logic [2:0]  c1;
  logic [1:0]  c2;
  logic        c3;
  logic        rot0, rot1, rot2, rot3;
  logic        en1, en2, en3, en4;
  function automatic logic [15:0] shl(input logic [15:0] x, input logic [3:0] n, input logic r);
    logic [31:0] t;
    t = {x, x} << n;
    return r ? t[31:16] : x << n;
  endfunction
  // a stage loads when empty or when its occupant moves on this cycle
  assign en4 = !v4 || bus.out_ready;
  assign en3 = !v3 || en4;
  assign en2 = !v2 || en3;
  assign en1 = !v1 || en2;
  assign bus.in_ready  = en1;
  assign bus.out_valid = v4;
  assign bus.out_data  = d4;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {v1, v2, v3, v4} <= '0;
      {d1, d2, d3, d4} <= '0;
      {c1, c2, c3}     <= '0;
    end else begin
      if (en1) begin
        v1 <= bus.in_valid;
        d1 <= shl(bus.in_data, {bus.in_ctrl[3], 3'b000}, rot0);
        c1 <= bus.in_ctrl[2:0];
      end
      if (en2) begin
        v2 <= v1;
        d2 <= shl(d1, {1'b0, c1[2], 2'b00}, rot1);
        c2 <= c1[1:0];
      end
      if (en3) begin
        v3 <= v2;
        d3 <= shl(d2, {2'b00, c2[1], 1'b0}, rot2);
        c3 <= c2[0];
      end
      if (en4) begin
        v4 <= v3;
        d4 <= shl(d3, {3'b000, c3}, rot3);
      end
    end
  end
`ifdef BARREL_SHIFT_ROTATE_EN
  logic r1, r2, r3;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r1, r2, r3} <= '0;
    end else begin
      if (en1) r1 <= bus.in_rot;
      if (en2) r2 <= r1;
      if (en3) r3 <= r2;
    end
  end
  assign rot0 = bus.in_rot;
  assign rot1 = r1;
  assign rot2 = r2;
  assign rot3 = r3;
`else
  logic unused_rot;
  assign unused_rot = bus.in_rot;
  assign rot0 = 1'b0;
  assign rot1 = 1'b0;
  assign rot2 = 1'b0;
  assign rot3 = 1'b0;
`endif
endmodule
